// File: rtl/sa_cdc_pkg.sv
// Shared definitions for the toggle-handshake CDC source and sink blocks.
package sa_cdc_pkg;
   typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} cdc_state_e;
   localparam int SYNC_STAGES = 3;
endpackage

// File: rtl/sa_sync3d_rst.sv
// Multi-flop synchronizer for a single async level, reset to 0.
module sa_sync3d_rst
   import sa_cdc_pkg::*;
(
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_d,
   output logic o_q
);
   // Chain must stay as discrete, un-retimed flops to bound metastability.
   (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_sync <= '0;
      else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
   end

   assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/sa_cdc_hs_src.sv
// Source side of a toggle req/ack crossing: holds one word on xfer_data per
// request toggle and waits for the resynchronized acknowledge toggle.
module sa_cdc_hs_src
   import sa_cdc_pkg::*;
#(
   parameter int              DW     = 32,
   parameter int              TO_W   = 16,
   parameter logic [TO_W-1:0] TO_CYC = 16'hFFFF,
   parameter int              CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic [DW-1:0]    xfer_data,
   output logic             req_tgl,
   input  logic             ack_tgl,
   output logic             busy,
   output logic             timeout_err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] xfer_cnt
);
   localparam bit              TO_EN   = (TO_CYC != '0);
   localparam logic [TO_W-1:0] TO_LAST = TO_CYC - TO_W'(1);

   cdc_state_e       r_state, w_state_nxt;
   logic             w_ack_s, w_accept, w_ack_match, w_to_inc, w_to_hit;
   logic             r_req_tgl, r_timeout_err;
   logic [DW-1:0]    r_xfer_data;
   logic [TO_W-1:0]  r_to_cnt;
   logic [CNT_W-1:0] r_xfer_cnt;

   sa_sync3d_rst u_ack_sync (
      .i_clk  (clk),
      .i_rstn (rstn),
      .i_d    (ack_tgl),
      .o_q    (w_ack_s)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_ack_match = 1'b0;
      w_to_inc    = 1'b0;
      w_to_hit    = 1'b0;
      case (r_state)
         IDLE: begin
            // A stray ack_s change here is deliberately ignored.
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (w_ack_s == r_req_tgl) begin
               w_ack_match = 1'b1;
               w_state_nxt = IDLE;
            end else if (TO_EN && (r_to_cnt != TO_CYC)) begin
               w_to_inc = 1'b1;
               w_to_hit = (r_to_cnt == TO_LAST);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_req_tgl     <= 1'b0;
         r_xfer_data   <= '0;
         r_to_cnt      <= '0;
         r_xfer_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_xfer_data <= in_data;
            r_req_tgl   <= ~r_req_tgl;
            r_to_cnt    <= '0;
         end else if (w_to_inc) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
         if (w_ack_match) r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
         // Set takes priority over a coincident clear.
         if (w_to_hit)     r_timeout_err <= 1'b1;
         else if (err_clr) r_timeout_err <= 1'b0;
      end
   end

   assign in_ready    = (r_state == IDLE);
   assign busy        = (r_state == WAIT_ACK);
   assign req_tgl     = r_req_tgl;
   assign xfer_data   = r_xfer_data;
   assign timeout_err = r_timeout_err;
   assign xfer_cnt    = r_xfer_cnt;
endmodule

// File: tb/tb_sa_cdc_hs_src.sv
// Self-checking bench for sa_cdc_hs_src against a transaction-level model.
module tb_sa_cdc_hs_src;
   localparam int DW  = 32;
   localparam int TO  = 8;
   localparam int CNT = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [DW-1:0] xfer_data;
   logic          req_tgl;
   logic          ack_tgl = 1'b0;
   logic          busy;
   logic          timeout_err;
   logic          err_clr = 1'b0;
   logic [1:0]    xfer_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: one outstanding word, acknowledged when the far toggle
   // seen three samples ago equals the last request toggle.
   logic          m_busy, m_req, m_err;
   logic [DW-1:0] m_data;
   int            m_cnt, m_wait;
   logic          m_hist[3];

   sa_cdc_hs_src #(.DW(DW), .TO_W(16), .TO_CYC(16'd8), .CNT_W(2)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .xfer_data(xfer_data), .req_tgl(req_tgl),
      .ack_tgl(ack_tgl), .busy(busy), .timeout_err(timeout_err),
      .err_clr(err_clr), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_busy = 0; m_req = 0; m_err = 0; m_data = '0; m_cnt = 0; m_wait = 0;
      for (int i = 0; i < 3; i++) m_hist[i] = 0;
   endtask

   task automatic model_step();
      logic set;
      set = 0;
      if (!rstn) begin
         model_reset();
         return;
      end
      if (!m_busy) begin
         if (in_valid) begin
            m_data = in_data; m_req = ~m_req; m_busy = 1; m_wait = 0;
         end
      end else if (m_hist[2] == m_req) begin
         m_busy = 0; m_cnt = (m_cnt + 1) % CNT;
      end else if (m_wait < TO) begin
         m_wait++;
         set = (m_wait == TO);
      end
      if (set) m_err = 1;
      else if (err_clr) m_err = 0;
      m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = ack_tgl;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rstn = 0; ack_tgl = 0; in_valid = 0; err_clr = 0;
      model_reset();
      tick(); tick();
      rstn = 1;
      tick();
   endtask

   task automatic test_reset();
      #3;
      n_tests++;
      if ({in_ready, busy, req_tgl, timeout_err} !== 4'b1000 || xfer_data !== '0 || xfer_cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL reset: rdy=%b busy=%b req=%b err=%b data=%h cnt=%0d, want 1 0 0 0 0 0",
                  in_ready, busy, req_tgl, timeout_err, xfer_data, xfer_cnt);
      end
      model_reset();
      tick();
      rstn = 1;
      tick(); tick();
   endtask

   task automatic test_single();
      in_valid = 1; in_data = 32'hDEADBEEF;
      tick();
      in_valid = 0; in_data = $urandom();
      n_tests++;
      if (req_tgl !== 1'b1 || xfer_data !== 32'hDEADBEEF || in_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_accept: req=%b data=%h rdy=%b busy=%b, want 1 deadbeef 0 1",
                  req_tgl, xfer_data, in_ready, busy);
      end
      tick(); tick();
      ack_tgl = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if (busy !== (i < 3) || in_ready !== (i == 3)) begin
            n_fail++;
            $display("FAIL single_ack_lat edge k+%0d: busy=%b rdy=%b, want busy=%b", i, busy, in_ready, i < 3);
         end
      end
      n_tests++;
      if (xfer_cnt !== 2'd1) begin
         n_fail++;
         $display("FAIL single_cnt: got %0d want 1", xfer_cnt);
      end
   endtask

   task automatic test_stall();
      logic [DW-1:0] d0, d1;
      d0 = $urandom();
      in_valid = 1; in_data = d0;
      tick();   // accepted at the earliest edge after the previous ack
      for (int i = 0; i < 3; i++) begin
         in_data = $urandom();
         tick();
         n_tests++;
         if (xfer_data !== d0 || req_tgl !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold %0d: data=%h req=%b busy=%b, want %h 0 1", i, xfer_data, req_tgl, busy, d0);
         end
      end
      ack_tgl = 0;
      for (int i = 0; i < 4; i++) begin
         in_data = $urandom();
         tick();
      end
      n_tests++;
      if (busy !== 1'b0 || xfer_data !== d0) begin
         n_fail++;
         $display("FAIL stall_release: busy=%b data=%h, want 0 %h", busy, xfer_data, d0);
      end
      d1 = $urandom(); in_data = d1;
      tick();
      in_valid = 0;
      n_tests++;
      if (req_tgl !== 1'b1 || xfer_data !== d1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_second: req=%b data=%h busy=%b, want 1 %h 1", req_tgl, xfer_data, busy, d1);
      end
      ack_tgl = 1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_timeout();
      int c0;
      c0 = m_cnt;
      in_valid = 1; in_data = $urandom();
      tick();
      in_valid = 0;
      for (int i = 1; i <= 11; i++) begin
         tick();
         n_tests++;
         if (timeout_err !== (i >= TO) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_cycle %0d: err=%b busy=%b, want %b 1", i, timeout_err, busy, i >= TO);
         end
      end
      err_clr = 1; tick(); err_clr = 0;
      n_tests++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_clr: err=%b busy=%b, want 0 1", timeout_err, busy);
      end
      ack_tgl = 0;
      for (int i = 0; i < 4; i++) tick();
      n_tests++;
      if (busy !== 1'b0 || xfer_cnt !== 2'((c0 + 1) % CNT)) begin
         n_fail++;
         $display("FAIL timeout_late_ack: busy=%b cnt=%0d, want 0 %0d", busy, xfer_cnt, (c0 + 1) % CNT);
      end
      // err_clr held through the setting edge: set must win.
      in_valid = 1; in_data = $urandom(); err_clr = 1;
      tick();
      in_valid = 0;
      for (int i = 1; i <= TO + 1; i++) tick_chk_set_wins(i);
      ack_tgl = 1; err_clr = 0;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic tick_chk_set_wins(input int i);
      tick();
      if (i >= TO) begin
         n_tests++;
         if (timeout_err !== (i == TO)) begin
            n_fail++;
            $display("FAIL set_wins cycle %0d: err=%b want %b", i, timeout_err, i == TO);
         end
      end
   endtask

   task automatic test_wrap();
      int exp_cnt[5] = '{1, 2, 3, 0, 1};
      do_reset();
      for (int t = 0; t < 5; t++) begin
         in_valid = 1; in_data = $urandom();
         tick();
         in_valid = 0; ack_tgl = ~ack_tgl;
         for (int i = 0; i < 4; i++) tick();
         n_tests++;
         if (xfer_cnt !== 2'(exp_cnt[t]) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap %0d: cnt=%0d busy=%b, want %0d 0", t, xfer_cnt, busy, exp_cnt[t]);
         end
      end
   endtask

   task automatic test_reset_mid();
      in_valid = 1; in_data = $urandom();
      tick();
      in_valid = 0;
      tick();
      #2 rstn = 0;
      #1;
      model_reset();
      n_tests++;
      if (req_tgl !== 1'b0 || xfer_data !== '0 || busy !== 1'b0 || in_ready !== 1'b1 || xfer_cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid: req=%b data=%h busy=%b rdy=%b cnt=%0d, want 0 0 0 1 0",
                  req_tgl, xfer_data, busy, in_ready, xfer_cnt);
      end
      ack_tgl = 0;
      tick(); tick();
      rstn = 1;
      tick();
      in_valid = 1; in_data = $urandom();
      tick();
      in_valid = 0; ack_tgl = 1;
      for (int i = 0; i < 4; i++) tick();
      n_tests++;
      if (busy !== 1'b0 || xfer_cnt !== 2'd1 || req_tgl !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_after: busy=%b cnt=%0d req=%b, want 0 1 1", busy, xfer_cnt, req_tgl);
      end
   endtask

   task automatic test_spurious();
      int c0;
      c0 = m_cnt;
      ack_tgl = ~ack_tgl;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_tests++;
         if (busy !== 1'b0 || in_ready !== 1'b1 || xfer_cnt !== 2'(c0) || req_tgl !== m_req) begin
            n_fail++;
            $display("FAIL spurious_idle %0d: busy=%b rdy=%b cnt=%0d req=%b, want 0 1 %0d %b",
                     i, busy, in_ready, xfer_cnt, req_tgl, c0, m_req);
         end
      end
      in_valid = 1; in_data = $urandom();
      tick();
      in_valid = 0;
      n_tests++;
      if (req_tgl !== ack_tgl || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL spurious_accept: req=%b busy=%b, want %b 1", req_tgl, busy, ack_tgl);
      end
      // The far toggle already matches the new request, so it completes next edge.
      tick();
      n_tests++;
      if (busy !== 1'b0 || xfer_cnt !== 2'((c0 + 1) % CNT)) begin
         n_fail++;
         $display("FAIL spurious_complete: busy=%b cnt=%0d, want 0 %0d", busy, xfer_cnt, (c0 + 1) % CNT);
      end
   endtask

   task automatic test_random();
      int fd;
      fd = 0;
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = $urandom();
         err_clr  = ($urandom_range(0, 15) == 0);
         if (ack_tgl != m_req) begin
            if (fd == 0) ack_tgl = m_req;
            else fd--;
         end else begin
            fd = $urandom_range(0, 12);
         end
         tick();
         n_tests++;
         if (busy !== m_busy || in_ready !== !m_busy || req_tgl !== m_req || xfer_data !== m_data ||
             timeout_err !== m_err || xfer_cnt !== 2'(m_cnt)) begin
            n_fail++;
            $display("FAIL random cyc %0d: busy=%b req=%b data=%h err=%b cnt=%0d, want %b %b %h %b %0d",
                     c, busy, req_tgl, xfer_data, timeout_err, xfer_cnt, m_busy, m_req, m_data, m_err, m_cnt);
         end
      end
      in_valid = 0; err_clr = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_stall();
      test_timeout();
      test_wrap();
      test_reset_mid();
      test_spurious();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
